fifo_uart_drain: RTL and testbench

- Downstream consumer of the FIFO wrapper's read side. On a one-cycle `start` pulse, it requests one word from the FIFO (`enable_read`), waits the FIFO read latency, and captures `value_to_read`.
- It then serialises the captured word on a UART TX line (8N1-style framing: start bit, DATA_WIDTH data bits LSB first, one stop bit).
- Gives the Arty A7 design a way to dump FIFO contents to the USB-UART bridge.

---
 rtl/fifo_uart_drain_pkg.sv | 7 +
 rtl/uart_baud_tick.sv | 22 ++
 rtl/fifo_uart_drain.sv | 94 +++++++++
 tb/tb_fifo_uart_drain.sv | 116 +++++++++++
 4 files changed

// File: rtl/fifo_uart_drain_pkg.sv
// fifo_uart_drain_pkg: shared defaults, line level and FSM encoding for the FIFO-to-UART drain
package fifo_uart_drain_pkg;
  localparam int BIT_DEPTH = 8;
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam logic LINE_IDLE = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP} state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider, held at zero while clear is high
module uart_baud_tick
  import fifo_uart_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt;
  assign tick = cnt == LAST;
  assign pre_tick = cnt == LAST - CW'(1);
  // count 0..CLKS_PER_BIT-1 and wrap, so consecutive bits stay aligned without a reload
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: reads one FIFO word per start request and sends it as a start/data/stop UART frame
module fifo_uart_drain
  import fifo_uart_drain_pkg::*;
#(
  parameter int DATA_WIDTH = BIT_DEPTH,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] value_to_read,
  output logic                  enable_read,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);
  state_t state;
  logic pending, tick, pre_tick, go, baud_clear, last_bit;
  logic [BW-1:0] bit_cnt;
  logic [2:0] wait_cnt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  assign go = pending | start;
  assign shift_nxt = shift >> 1;
  assign last_bit = bit_cnt == LAST_BIT;
  assign baud_clear = state inside {S_IDLE, S_REQ, S_WAIT};
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(baud_clear),
    .tick(tick),
    .pre_tick(pre_tick)
  );
  // frame sequencer; every output is set on the edge that enters the cycle it describes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      tx <= LINE_IDLE;
      enable_read <= 1'b0;
      busy <= 1'b0;
      tx_done <= 1'b0;
      pending <= 1'b0;
      bit_cnt <= '0;
      wait_cnt <= '0;
      shift <= '0;
    end else begin
      enable_read <= 1'b0;
      tx_done <= 1'b0;
      pending <= (state != S_IDLE) && go;
      case (state)
        S_IDLE: if (start) begin
          state <= S_REQ;
          enable_read <= 1'b1;
          busy <= 1'b1;
        end
        S_REQ: begin
          state <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_cnt == LAST_WAIT) begin
            shift <= value_to_read;
            state <= S_START;
            tx <= 1'b0;
          end
        end
        S_START: if (tick) begin
          state <= S_DATA;
          tx <= shift[0];
          bit_cnt <= '0;
        end
        S_DATA: if (tick) begin
          shift <= shift_nxt;
          bit_cnt <= bit_cnt + BW'(1);
          state <= last_bit ? S_STOP : S_DATA;
          tx <= last_bit ? LINE_IDLE : shift_nxt[0];
        end
        S_STOP: begin
          tx_done <= pre_tick;
          if (tick) begin
            state <= go ? S_REQ : S_IDLE;
            enable_read <= go;
            busy <= go;
            pending <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: randomized and directed checks of fifo_uart_drain against a frame-timing model
module tb_fifo_uart_drain;
  localparam int N = 8;
  localparam int C = 4;
  localparam int L = 2;
  localparam int F = (N + 2) * C;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [N-1:0] value_to_read = '0;
  logic enable_read, tx, busy, tx_done;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r = -1;
  bit pend = 1'b0;
  logic [N-1:0] w = '0;
  logic [N-1:0] words[$];
  fifo_uart_drain #(.DATA_WIDTH(N), .CLKS_PER_BIT(C), .READ_LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .value_to_read(value_to_read),
    .enable_read(enable_read),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [3:0] model_out(input int c);
    int off, t, b;
    off = c - r;
    if (r < 0 || off < 0 || off > L + F) return 4'b0010;
    if (off == 0) return 4'b1110;
    if (off <= L) return 4'b0110;
    t = off - 1 - L;
    b = t / C;
    return {1'b0, 1'b1, (b == 0) ? 1'b0 : (b <= N) ? w[b-1] : 1'b1, t == F - 1};
  endfunction
  task automatic step(input bit st);
    int off;
    logic [3:0] e;
    @(posedge clk);
    #1;
    cyc++;
    e = model_out(cyc);
    check("enable_read", enable_read, e[3]);
    check("busy", busy, e[2]);
    check("tx", tx, e[1]);
    check("tx_done", tx_done, e[0]);
    start = st;
    off = cyc - r;
    if (r >= 0 && off == L && words.size() > 0) value_to_read = words.pop_front();
    else value_to_read = N'($urandom);
    if (rst) begin
      r = -1;
      pend = 1'b0;
    end else if (r < 0) begin
      if (st) r = cyc + 1;
    end else begin
      if (off == L) w = value_to_read;
      if (off == L + F) begin
        r = (pend || st) ? cyc + 1 : -1;
        pend = 1'b0;
      end else pend = pend | st;
    end
  endtask
  initial begin
    repeat (3) step(1'b0);
    rst = 1'b0;
    repeat (100) step(1'b0);
    words = '{8'hA5};
    step(1'b1);
    repeat (45) step(1'b0);
    words = '{8'h3C, 8'hFF};
    step(1'b1);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (9) step(1'b0);
    step(1'b1);
    repeat (14) step(1'b0);
    step(1'b1);
    repeat (100) step(1'b0);
    words = '{8'h5A, 8'hC3};
    step(1'b1);
    repeat (42) step(1'b0);
    step(1'b1);
    repeat (100) step(1'b0);
    words = '{8'h00};
    step(1'b1);
    repeat (21) step(1'b0);
    check("pre_reset_tx", tx, 1'b0);
    rst = 1'b1;
    r = -1;
    pend = 1'b0;
    #1;
    check("async_tx", tx, 1'b1);
    check("async_busy", busy, 1'b0);
    check("async_enable_read", enable_read, 1'b0);
    check("async_tx_done", tx_done, 1'b0);
    repeat (3) step(1'b0);
    rst = 1'b0;
    repeat (60) step(1'b0);
    repeat (1500) step($urandom_range(0, 39) == 0);
    repeat (60) step(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
